// File: rtl/srt_div_pkg.sv
// Shared constants, digit encodings and FSM state type for the radix-4 SRT divider.
package srt_div_pkg;

    localparam int RADIX = 4;
    localparam int WIDTH = 24;
    localparam int NDIG  = WIDTH / 2;

    localparam logic [2:0] DIG_P2 = 3'b010;
    localparam logic [2:0] DIG_P1 = 3'b001;
    localparam logic [2:0] DIG_0  = 3'b000;
    localparam logic [2:0] DIG_M1 = 3'b111;
    localparam logic [2:0] DIG_M2 = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/srt4_qsel.sv
// Radix-4 SRT digit selection: compares the shifted residual p against +-d/2 and +-3d/2
// and returns the digit together with the multiple q*d to subtract.
module srt4_qsel #(
    parameter int WW = srt_div_pkg::WIDTH + 5
) (
    input  logic signed [WW-1:0] p,
    input  logic        [WW-1:0] d,
    output logic        [2:0]    digit,
    output logic signed [WW-1:0] qd
);
    import srt_div_pkg::*;

    logic signed [WW-1:0] half_d;
    logic signed [WW-1:0] three_half_d;

    // d carries two spare low zero bits, so both thresholds are exact.
    always_comb begin
        half_d       = $signed(d >> 1);
        three_half_d = $signed(d) + half_d;
        digit        = DIG_0;
        qd           = '0;
        if (p >= three_half_d) begin
            digit = DIG_P2;
            qd    = $signed(d << 1);
        end else if (p >= half_d) begin
            digit = DIG_P1;
            qd    = $signed(d);
        end else if (p >= -half_d) begin
            digit = DIG_0;
            qd    = '0;
        end else if (p >= -three_half_d) begin
            digit = DIG_M1;
            qd    = -$signed(d);
        end else begin
            digit = DIG_M2;
            qd    = -$signed(d << 1);
        end
    end

endmodule

// File: rtl/srt4_digit_recurrence.sv
// Radix-4 SRT residual recurrence: one quotient digit per cycle, streamed to the
// on-the-fly converter, followed by a done pulse carrying the final residual sign.
module srt4_digit_recurrence #(
    parameter int WIDTH = srt_div_pkg::WIDTH,
    parameter int NDIG  = WIDTH / 2,
    parameter int PW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             CE,
    output logic [2:0]       q,
    output logic [2:0]       q_abs,
    output logic [PW-1:0]    pointer,
    output logic             done,
    output logic             rem_neg,
    output logic             err
);
    import srt_div_pkg::*;

    // Residual: 3 integer bits and WIDTH+2 fraction bits; x/4 needs exactly two extra.
    localparam int WW = WIDTH + 5;
    localparam int KW = $clog2(NDIG + 1);
    localparam int SH = $clog2(RADIX);

    state_t                state_q, state_d;
    logic signed [WW-1:0]  w_q, w_d;
    logic        [WW-1:0]  d_q, d_d;
    logic        [KW-1:0]  k_q, k_d;
    logic                  ce_q, ce_d;
    logic        [2:0]     q_q, q_d;
    logic        [2:0]     q_abs_q, q_abs_d;
    logic        [PW-1:0]  pointer_q, pointer_d;
    logic                  rem_neg_q, rem_neg_d;
    logic                  err_q, err_d;

    logic signed [WW-1:0]  p;
    logic        [2:0]     digit;
    logic signed [WW-1:0]  qd;

    assign p = w_q <<< SH;

    srt4_qsel #(.WW(WW)) u_qsel (
        .p     (p),
        .d     (d_q),
        .digit (digit),
        .qd    (qd)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            w_q       <= '0;
            d_q       <= '0;
            k_q       <= '0;
            ce_q      <= 1'b0;
            q_q       <= '0;
            q_abs_q   <= '0;
            pointer_q <= '0;
            rem_neg_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            d_q       <= d_d;
            k_q       <= k_d;
            ce_q      <= ce_d;
            q_q       <= q_d;
            q_abs_q   <= q_abs_d;
            pointer_q <= pointer_d;
            rem_neg_q <= rem_neg_d;
            err_q     <= err_d;
        end
    end

    // An extra ITER pass with k == NDIG drains the last registered digit before DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = divisor[WIDTH-1] ? ITER : DONE;
                end
            end
            ITER: begin
                if (k_q == KW'(NDIG)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_d       = w_q;
        d_d       = d_q;
        k_d       = k_q;
        ce_d      = 1'b0;
        q_d       = q_q;
        q_abs_d   = q_abs_q;
        pointer_d = pointer_q;
        rem_neg_d = rem_neg_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_d       = {{(WW-WIDTH){1'b0}}, dividend};
                    d_d       = {3'b000, divisor, 2'b00};
                    k_d       = '0;
                    pointer_d = '0;
                    rem_neg_d = 1'b0;
                    err_d     = ~divisor[WIDTH-1];
                end
            end
            ITER: begin
                if (k_q < KW'(NDIG)) begin
                    ce_d      = 1'b1;
                    q_d       = digit;
                    q_abs_d   = (~digit) + 3'd1;
                    pointer_d = PW'(k_q);
                    w_d       = p - qd;
                    k_d       = k_q + 1'b1;
                end else begin
                    rem_neg_d = w_q[WW-1];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        err  = (state_q == DONE) && err_q;
    end

    assign CE      = ce_q;
    assign q       = q_q;
    assign q_abs   = q_abs_q;
    assign pointer = pointer_q;
    assign rem_neg = rem_neg_q;

endmodule

// File: tb/tb_srt4_digit_recurrence.sv
// Directed-vector and scoreboard bench for the radix-4 SRT recurrence stage.
module tb_srt4_digit_recurrence;

    localparam int WIDTH = 24;
    localparam int NDIG  = 12;
    localparam int PW    = 4;
    localparam int NVEC  = 9;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [WIDTH-1:0]  dividend;
    logic [WIDTH-1:0]  divisor;
    logic              busy;
    logic              CE;
    logic [2:0]        q;
    logic [2:0]        q_abs;
    logic [PW-1:0]     pointer;
    logic              done;
    logic              rem_neg;
    logic              err;

    int n_applied = 0;
    int n_fail    = 0;

    logic [3*NDIG-1:0] res_digits;
    int                res_nce;
    int                res_first_ce;
    int                res_done_at;
    logic              res_rem_neg;
    logic              res_err;
    logic              res_ptr_ok;
    logic              res_qabs_ok;
    logic              res_busy_ok;
    logic              res_idle_after;

    typedef struct {
        logic [WIDTH-1:0]  x;
        logic [WIDTH-1:0]  d;
        int                glitch;
        logic [3*NDIG-1:0] digs;
        logic              rem;
        logic              er;
    } vec_t;

    vec_t vecs[NVEC];

    srt4_digit_recurrence #(.WIDTH(WIDTH), .NDIG(NDIG), .PW(PW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .CE       (CE),
        .q        (q),
        .q_abs    (q_abs),
        .pointer  (pointer),
        .done     (done),
        .rem_neg  (rem_neg),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Issues one start, then observes every cycle from the start edge (index 0) to done,
    // optionally pulsing a junk start at cycle index glitch_at (done+1 means the done cycle).
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d, input int glitch_at);
        logic [2:0] neg_q;
        dividend = x;
        divisor  = d;
        start    = 1'b1;
        tick();
        start          = 1'b0;
        res_digits     = '0;
        res_nce        = 0;
        res_first_ce   = -1;
        res_done_at    = -1;
        res_rem_neg    = 1'b0;
        res_err        = 1'b0;
        res_ptr_ok     = 1'b1;
        res_qabs_ok    = 1'b1;
        res_busy_ok    = 1'b1;
        for (int cyc = 0; cyc <= 40; cyc++) begin
            if (cyc > 0) begin
                if (cyc == glitch_at) begin
                    dividend = 24'h123456;
                    divisor  = 24'hC00000;
                    start    = 1'b1;
                end
                tick();
                start    = 1'b0;
                dividend = x;
                divisor  = d;
            end
            if (busy !== 1'b1) res_busy_ok = 1'b0;
            if (CE === 1'b1) begin
                if (res_nce == 0) res_first_ce = cyc;
                if (pointer !== PW'(res_nce)) res_ptr_ok = 1'b0;
                neg_q = ~q + 3'd1;
                if (q_abs !== neg_q) res_qabs_ok = 1'b0;
                if (res_nce < NDIG) res_digits[3*res_nce +: 3] = q;
                res_nce++;
            end
            if (done === 1'b1) begin
                res_done_at = cyc;
                res_rem_neg = rem_neg;
                res_err     = err;
                break;
            end
        end
        if (glitch_at == res_done_at + 1) begin
            dividend = 24'h123456;
            divisor  = 24'hC00000;
            start    = 1'b1;
        end
        tick();
        start          = 1'b0;
        res_idle_after = (busy === 1'b0) && (done === 1'b0) && (CE === 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] rx;
        logic [WIDTH-1:0] rd;
        logic signed [2:0] dg;
        longint qk;
        longint qacc;
        longint wres;
        logic bound_ok;
        int ce_seen;
        int stray;

        vecs[0] = '{24'h800000, 24'h800000, 0,  36'b001, 1'b0, 1'b0};
        vecs[1] = '{24'h600000, 24'h800000, 0,  36'b111_001, 1'b0, 1'b0};
        vecs[2] = '{24'hFFFFFF, 24'h800000, 0,  36'b010, 1'b1, 1'b0};
        vecs[3] = '{24'h500000, 24'h800000, 0,  36'b110_111_001, 1'b0, 1'b0};
        vecs[4] = '{24'hC00000, 24'h800000, 0,  36'b110_010, 1'b0, 1'b0};
        vecs[5] = '{24'h400000, 24'hC00000, 0,  36'b001_001_001_001_001_001_001_001_001_001_001_000, 1'b0, 1'b0};
        vecs[6] = '{24'h123456, 24'h400000, 0,  36'b0, 1'b0, 1'b1};
        vecs[7] = '{24'h600000, 24'h800000, 5,  36'b111_001, 1'b0, 1'b0};
        vecs[8] = '{24'h800000, 24'h800000, 14, 36'b001, 1'b0, 1'b0};

        RST      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        checkOutput("reset busy",    64'(busy),    64'(0));
        checkOutput("reset CE",      64'(CE),      64'(0));
        checkOutput("reset q",       64'(q),       64'(0));
        checkOutput("reset q_abs",   64'(q_abs),   64'(0));
        checkOutput("reset pointer", 64'(pointer), 64'(0));
        checkOutput("reset done",    64'(done),    64'(0));
        checkOutput("reset rem_neg", 64'(rem_neg), 64'(0));
        checkOutput("reset err",     64'(err),     64'(0));
        RST = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].x, vecs[i].d, vecs[i].glitch);
            checkOutput($sformatf("v%0d digits", i),   64'(res_digits),   64'(vecs[i].digs));
            checkOutput($sformatf("v%0d ce_count", i), 64'(res_nce),      64'(vecs[i].er ? 0 : NDIG));
            checkOutput($sformatf("v%0d first_ce", i), 64'(res_first_ce), 64'(vecs[i].er ? -1 : 1));
            checkOutput($sformatf("v%0d done_at", i),  64'(res_done_at),  64'(vecs[i].er ? 0 : NDIG + 1));
            checkOutput($sformatf("v%0d rem_neg", i),  64'(res_rem_neg),  64'(vecs[i].rem));
            checkOutput($sformatf("v%0d err", i),      64'(res_err),      64'(vecs[i].er));
            checkOutput($sformatf("v%0d pointer", i),  64'(res_ptr_ok),   64'(1));
            checkOutput($sformatf("v%0d q_abs", i),    64'(res_qabs_ok),  64'(1));
            checkOutput($sformatf("v%0d busy", i),     64'(res_busy_ok),  64'(1));
            checkOutput($sformatf("v%0d idle", i),     64'(res_idle_after), 64'(1));
        end

        // Abort a run after five digits and confirm nothing more comes out.
        dividend = 24'h800000;
        divisor  = 24'h800000;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        ce_seen = 0;
        for (int c = 0; c < 20 && ce_seen < 5; c++) begin
            tick();
            if (CE === 1'b1) ce_seen++;
        end
        checkOutput("midrst ce_before", 64'(ce_seen), 64'(5));
        RST = 1'b1;
        tick();
        checkOutput("midrst busy",    64'(busy),    64'(0));
        checkOutput("midrst CE",      64'(CE),      64'(0));
        checkOutput("midrst pointer", 64'(pointer), 64'(0));
        RST   = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (CE !== 1'b0 || done !== 1'b0) stray++;
        end
        checkOutput("midrst stray", 64'(stray), 64'(0));

        // Random operands back to back; residuals are rebuilt from the digit stream alone.
        for (int r = 0; r < 6; r++) begin
            rx = WIDTH'($urandom);
            rd = {1'b1, 23'($urandom)};
            applyStimulus(rx, rd, 0);
            checkOutput($sformatf("r%0d ce_count", r), 64'(res_nce), 64'(NDIG));
            bound_ok = 1'b1;
            qacc     = 0;
            wres     = 0;
            for (int k = 0; k < NDIG; k++) begin
                dg = res_digits[3*k +: 3];
                if (dg > 2 || dg < -2) bound_ok = 1'b0;
                qk   = dg;
                qacc = qacc * 4 + qk;
                wres = (longint'(rx) <<< (2 * (k + 1))) - qacc * longint'(rd) * 4;
                if (3 * (wres < 0 ? -wres : wres) > 8 * longint'(rd)) bound_ok = 1'b0;
            end
            checkOutput($sformatf("r%0d bound", r),   64'(bound_ok),    64'(1));
            checkOutput($sformatf("r%0d rem_neg", r), 64'(res_rem_neg), 64'(wres < 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule

// File: doc/srt4_digit_recurrence.md
Name: srt4_digit_recurrence

Overview:
- Upstream stage of the radix-4 SRT divider.
- Takes a normalized dividend/divisor mantissa pair and runs the residual recurrence, one step per cycle.
- Each step emits a signed quotient digit in {-2..2}, its complement code and a digit index, qualified by CE, straight into the on-the-fly converter.
- After the last digit it reports the sign of the final residual, which the back end uses for quotient correction.

Parameters:
- WIDTH, 24, mantissa width in bits; must be even.
- NDIG, WIDTH/2, number of radix-4 digits produced (12 by default).
- PW, 4, width of the pointer output; must satisfy 2^PW >= NDIG.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; operands sampled on the same edge.
- dividend  in  WIDTH  x, unsigned fraction in [0,1).
- divisor  in  WIDTH  d, unsigned fraction; MSB must be 1, i.e. d in [1/2,1).
- busy  out  1  high from the edge after an accepted start through the done cycle.
- CE  out  1  digit-valid strobe to the converter.
- q  out  3  quotient digit, two's complement, in {-2..2}.
- q_abs  out  3  (~q)+1 mod 8, the complement code the converter consumes.
- pointer  out  PW  index of the current digit, 0..NDIG-1.
- done  out  1  one-cycle completion pulse.
- rem_neg  out  1  final residual < 0; valid while done=1, held until the next start.
- err  out  1  with done, marks a non-normalized divisor.

Behaviour:
- Reset: state IDLE. busy, CE, q, q_abs, pointer, done, rem_neg and err are all 0. Reset mid-operation aborts immediately; no further CE is issued.
- Residual w: two's complement, 3 integer bits + (WIDTH+2) fraction bits. All arithmetic is exact; no truncation.
- IDLE: start=1 with divisor MSB=1 loads w0 = x/4 and d, clears the digit counter k, and moves to ITER.
- IDLE, non-normalized divisor: start=1 with divisor MSB=0 goes to DONE with err=1, no CE cycles, and rem_neg=0.
- ITER, each cycle: form p = 4w and select the digit:
  - q=2 if p >= 1.5d
  - q=1 if 0.5d <= p < 1.5d
  - q=0 if -0.5d <= p < 0.5d
  - q=-1 if -1.5d <= p < -0.5d
  - q=-2 if p < -1.5d
  - Then update w <= p - q*d.
- Comparison constants: 1.5d = d + (d>>1); 0.5d = d>>1. Boundaries are inclusive exactly as listed.
- Invariant: |w| <= (2/3)d holds every step. Quotient sum(q_j * 4^-j) = x/(4d) - w_final*4^-NDIG/d.
- Output registration: q, q_abs and pointer are registered. The digit selected in ITER step k appears on the outputs in the cycle after that step, with CE=1 and pointer=k.
- Digit timing: the start edge is T0. Digit k is presented after edge T(k+1), so CE is high for exactly NDIG consecutive cycles, pointer runs 0..NDIG-1, and there are no gaps.
- DONE: after edge T(NDIG+1), CE=0 and done=1 for one cycle. rem_neg = sign of w_NDIG. busy is still 1. The next edge returns to IDLE with busy=0.
- Between digits: while CE=0, q and q_abs hold their last values and pointer holds its value. On a new start, pointer restarts at 0.
- start while busy: ignored; operands are not resampled.
- start in the done cycle: ignored. The earliest new start is the first IDLE cycle.

Decomposition:
- Shared package srt_div_pkg holds:
  - constants RADIX=4, WIDTH, NDIG;
  - digit encodings DIG_P2=3'b010, DIG_P1=3'b001, DIG_0=3'b000, DIG_M1=3'b111, DIG_M2=3'b110;
  - the FSM state enum {IDLE, ITER, DONE}.
- Sub-module srt4_qsel (combinational): inputs p and d; outputs the 3-bit digit plus the selected multiple q*d. It is instantiated once, so the selection logic can be checked on its own.

Test Plan:
- Reset mid-run: start with x=0x800000, d=0x800000, assert RST after 5 CE cycles -> the next cycle shows busy=0, CE=0, pointer=0, and no further CE or done.
- Exact quotient: x=0x800000, d=0x800000 -> CE cycles T1..T12 give q = 1,0,0,...,0 and pointer = 0..11; done at T13 with rem_neg=0, err=0.
- Mixed signs: x=0x600000, d=0x800000 -> q = 1,-1,0,...,0 with q_abs = 7,1,0,...; rem_neg=0. Value 3/16 = x/(4d).
- Boundary and negative residual: x=0xFFFFFF, d=0x800000 -> q = 2 then eleven 0s. The last step hits p = -0.5d exactly and must give q=0; rem_neg=1.
- Errors and ignored starts:
  - divisor=0x400000 -> done=1, err=1 on the cycle after start, zero CE cycles.
  - start pulsed while busy -> digit stream unchanged, still exactly 12 CE cycles.
- Randomized back-to-back: random x, normalized d, start on the first IDLE cycle -> the scoreboard checks sum(q_j*4^-j)*4d - x against the residual sign, and checks |w| <= (2/3)d every step.
